irq_sched: RTL and testbench

IRQ_SCHED -- requirements
Module: irq_sched

---
 rtl/pld_pkg.sv | 36 +++
 rtl/irq_edge_det.sv | 29 ++
 rtl/irq_sched.sv | 126 ++++++++++++
 tb/tb_irq_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pld_pkg.sv
// Shared definitions for the DSP interrupt scheduler:
// FSM states, event source indices and default sizing.
package pld_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } irq_state_e;

  localparam int SRC_WIL_IN1 = 0;
  localparam int SRC_WIL_IN2 = 1;
  localparam int SRC_WIL_IN3 = 2;
  localparam int SRC_WIL_OUT = 3;
  localparam int SRC_KEY     = 4;
  localparam int SRC_FW      = 5;
  localparam int SRC_FQ      = 6;
  localparam int SRC_SPARE   = 7;

  localparam int DEF_N_SRC   = 8;
  localparam int DEF_HOLDOFF = 16;
  localparam int DEF_TIMEOUT = 65535;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [2:0] lowest_idx(
    input logic [7:0] v
  );
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// Falling-edge detector for the active-low event lines.
// Stays disarmed for one cycle after reset so lines held low emit nothing.
module irq_edge_det
  import pld_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_src_n,
  output logic [N_SRC-1:0] o_fall
);

  logic [N_SRC-1:0] r_hist;
  logic             r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist  <= '1;
      r_armed <= 1'b0;
    end else begin
      r_hist  <= i_src_n;
      r_armed <= 1'b1;
    end
  end

  assign o_fall = {N_SRC{r_armed}} & r_hist & ~i_src_n;

endmodule

// File: rtl/irq_sched.sv
// Pending/mask latch, priority vector and irq_n
// assertion FSM with holdoff and ack timeout.
module irq_sched
  import pld_pkg::*;
#(
  parameter int N_SRC   = DEF_N_SRC,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_n,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             clr_wr,
  input  logic [N_SRC-1:0] clr_wdata,
  input  logic             ack,
  output logic [N_SRC-1:0] pend,
  output logic [N_SRC-1:0] mask,
  output logic [2:0]       vec,
  output logic             vec_valid,
  output logic             irq_n
);

  localparam int HO_W = $clog2(HOLDOFF + 1);
  // Last HOLDOFF cycle is spent in IDLE, so the
  // counter stops one short of HOLDOFF.
  localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF - 2);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);

  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_mask;
  logic [2:0]       r_vec;
  logic             r_vec_valid;
  logic             r_irq_n;
  irq_state_e       r_state;
  logic [HO_W-1:0]  r_ho_cnt;
  logic [15:0]      r_to_cnt;

  logic [N_SRC-1:0] w_fall;
  logic [N_SRC-1:0] w_active;
  logic [N_SRC-1:0] w_clr;
  logic [7:0]       w_vec_oh;
  logic             w_ack_hit;

  irq_edge_det #(
    .N_SRC(N_SRC)
  ) u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_src_n(src_n),
    .o_fall (w_fall)
  );

  assign w_active  = r_pend & r_mask;
  assign w_ack_hit = (r_state == ST_ASSERT) && ack;
  assign w_vec_oh  = 8'd1 << r_vec;

  always_comb begin
    w_clr = '0;
    if (clr_wr) w_clr = clr_wdata;
    if (w_ack_hit) w_clr = w_clr | w_vec_oh[N_SRC-1:0];
  end

  // New events win over any clear of the same bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= '0;
      r_mask      <= '0;
      r_vec       <= 3'd0;
      r_vec_valid <= 1'b0;
    end else begin
      r_pend      <= (r_pend & ~w_clr) | w_fall;
      if (mask_wr) r_mask <= mask_wdata;
      r_vec       <= lowest_idx(8'(w_active));
      r_vec_valid <= |w_active;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_irq_n  <= 1'b1;
      r_ho_cnt <= '0;
      r_to_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_vec_valid) begin
            r_state  <= ST_ASSERT;
            r_irq_n  <= 1'b0;
            r_to_cnt <= '0;
          end
        end
        ST_ASSERT: begin
          if (ack || !r_vec_valid ||
              r_to_cnt == TO_LAST) begin
            r_state  <= ST_HOLDOFF;
            r_irq_n  <= 1'b1;
            r_ho_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        ST_HOLDOFF: begin
          if (r_ho_cnt == HO_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_ho_cnt <= r_ho_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_irq_n <= 1'b1;
        end
      endcase
    end
  end

  assign pend      = r_pend;
  assign mask      = r_mask;
  assign vec       = r_vec;
  assign vec_valid = r_vec_valid;
  assign irq_n     = r_irq_n;

endmodule

// File: tb/tb_irq_sched.sv
// Randomised and directed bench for irq_sched with a
// run-length reference model feeding a scoreboard.
module tb_irq_sched;

  localparam int NS = 8;
  localparam int HO = 16;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] src_n;
  logic          mask_wr;
  logic [NS-1:0] mask_wdata;
  logic          clr_wr;
  logic [NS-1:0] clr_wdata;
  logic          ack;
  logic [NS-1:0] pend;
  logic [NS-1:0] mask;
  logic [2:0]    vec;
  logic          vec_valid;
  logic          irq_n;

  always #5 clk = ~clk;

  irq_sched #(
    .N_SRC  (NS),
    .HOLDOFF(HO),
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_n     (src_n),
    .mask_wr   (mask_wr),
    .mask_wdata(mask_wdata),
    .clr_wr    (clr_wr),
    .clr_wdata (clr_wdata),
    .ack       (ack),
    .pend      (pend),
    .mask      (mask),
    .vec       (vec),
    .vec_valid (vec_valid),
    .irq_n     (irq_n)
  );

  typedef struct {
    logic [7:0] pend;
    logic [7:0] mask;
    logic [2:0] vec;
    logic       vv;
    logic       irq_n;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: pending set, mask, and how long
  // irq_n has held its present level.
  logic [7:0] m_pend, m_mask, m_prev;
  logic [2:0] m_vec;
  logic       m_vv, m_low, m_prev_ok;
  int         m_run;

  function automatic logic [2:0] first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already set.
  task automatic cyc();
    logic [7:0] act, clr, ev;
    exp_t e;
    act = m_pend & m_mask;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_vec = 0; m_vv = 0;
      m_low = 0; m_run = HO; m_prev_ok = 0;
    end else begin
      clr = clr_wr ? clr_wdata : 8'h00;
      ev  = m_prev_ok ? (m_prev & ~src_n) : 8'h00;
      if (m_low) begin
        if (ack) clr[m_vec] = 1'b1;
        if (ack || !m_vv || m_run >= TO) begin
          m_low = 0; m_run = 1;
        end else m_run++;
      end else begin
        if (m_vv && m_run >= HO) begin
          m_low = 1; m_run = 1;
        end else if (m_run < HO) m_run++;
      end
      m_pend = (m_pend & ~clr) | ev;
      if (mask_wr) m_mask = mask_wdata;
      m_vv  = (act != 0);
      m_vec = first_set(act);
      m_prev = src_n;
      m_prev_ok = 1;
    end
    e.pend = m_pend; e.mask = m_mask; e.vec = m_vec;
    e.vv = m_vv; e.irq_n = ~m_low;
    sb.push_back(e);
    @(negedge clk);
    mask_wr = 0; clr_wr = 0; ack = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("sb_pend", 32'(pend), 32'(e.pend));
        cmp("sb_mask", 32'(mask), 32'(e.mask));
        cmp("sb_vec", 32'(vec), 32'(e.vec));
        cmp("sb_vec_valid", 32'(vec_valid), 32'(e.vv));
        cmp("sb_irq_n", 32'(irq_n), 32'(e.irq_n));
      end
    end
  end

  int n;

  initial begin
    rst = 1; src_n = 8'hFF; mask_wr = 0; mask_wdata = 0;
    clr_wr = 0; clr_wdata = 0; ack = 0;
    @(negedge clk);
    idle(2);
    cmp("rst_pend", 32'(pend), 32'h0);
    cmp("rst_irq_n", 32'(irq_n), 32'h1);
    cmp("rst_vec_valid", 32'(vec_valid), 32'h0);
    rst = 0;

    // Single key event, ack, then no reassert.
    mask_wr = 1; mask_wdata = 8'hFF; cyc();
    src_n = 8'hEF; cyc();
    cmp("key_pend", 32'(pend), 32'h10);
    src_n = 8'hFF; cyc();
    cmp("key_vec", 32'(vec), 32'd4);
    cyc();
    cmp("key_irq_low", 32'(irq_n), 32'h0);
    ack = 1; cyc();
    cmp("key_ack_pend", 32'(pend), 32'h0);
    cmp("key_ack_irq", 32'(irq_n), 32'h1);
    idle(20);
    cmp("key_stays_high", 32'(irq_n), 32'h1);

    // Two sources: priority, holdoff gap, reassert.
    src_n = 8'hBE; cyc();
    src_n = 8'hFF; cyc();
    cmp("pri_vec", 32'(vec), 32'd0);
    cyc();
    ack = 1; cyc();
    cmp("pri_ack_pend", 32'(pend), 32'h40);
    n = 1;
    while (irq_n === 1'b1 && n < 60) begin
      cyc();
      if (irq_n === 1'b1) n++;
    end
    cmp("pri_holdoff_len", 32'(n), 32'd16);
    cmp("pri_revec", 32'(vec), 32'd6);
    ack = 1; cyc();
    idle(20);

    // Event latched while masked, enabled later.
    mask_wr = 1; mask_wdata = 8'h00; cyc();
    src_n = 8'hFB; cyc();
    cmp("msk_pend", 32'(pend), 32'h04);
    src_n = 8'hFF; idle(3);
    cmp("msk_irq_high", 32'(irq_n), 32'h1);
    mask_wr = 1; mask_wdata = 8'h04; cyc();
    idle(2);
    cmp("msk_irq_low", 32'(irq_n), 32'h0);
    ack = 1; cyc();
    idle(20);

    // Set beats clear; timeout retrigger.
    mask_wr = 1; mask_wdata = 8'hFF; cyc();
    src_n = 8'hFE; cyc();
    src_n = 8'hFF; cyc();
    src_n = 8'hFE; clr_wr = 1; clr_wdata = 8'h01; cyc();
    cmp("setclr_pend", 32'(pend), 32'h01);
    src_n = 8'hFF;
    n = 0;
    while (irq_n !== 1'b0 && n < 50) begin cyc(); n++; end
    n = 1;
    while (irq_n === 1'b0 && n < 300) begin
      cyc();
      if (irq_n === 1'b0) n++;
    end
    cmp("to_low_len", 32'(n), 32'd100);
    n = 1;
    while (irq_n === 1'b1 && n < 60) begin
      cyc();
      if (irq_n === 1'b1) n++;
    end
    cmp("to_high_len", 32'(n), 32'd16);
    ack = 1; cyc();
    idle(20);

    // Reset mid-assert with a source held low.
    src_n = 8'hDF; cyc();
    idle(2);
    cmp("rsta_irq_low", 32'(irq_n), 32'h0);
    rst = 1; cyc();
    cmp("rsta_irq", 32'(irq_n), 32'h1);
    cmp("rsta_pend", 32'(pend), 32'h0);
    rst = 0; idle(5);
    cmp("rsta_no_event", 32'(pend), 32'h0);
    src_n = 8'hFF; cyc();
    src_n = 8'hDF; cyc();
    cmp("rsta_new_event", 32'(pend), 32'h20);
    src_n = 8'hFF; idle(5);

    // Random traffic; ack is rare in the second half.
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] flip;
      flip = 0;
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
      src_n = src_n ^ flip;
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 15) == 0) begin
        mask_wr = 1; mask_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 11) == 0) begin
        clr_wr = 1; clr_wdata = 8'($urandom);
      end
      if (c < 1500) ack = ($urandom_range(0, 2) == 0);
      else ack = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 0;
    idle(2);

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_drain: got %0d left expected 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
